// File: rtl/packet_handler_deadlock_pkg.sv
// Shared types and report-word layout for the packet handler deadlock reporter.
package packet_handler_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_REPORT  = 2'd2,
    ST_LATCHED = 2'd3
  } dl_state_e;

  localparam int unsigned TS_LSB     = 32;
  localparam int unsigned TS_W       = 32;
  localparam int unsigned CNT_LSB    = 24;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned INFO_LSB   = 0;
  localparam int unsigned INFO_MAX_W = 16;

  localparam logic [7:0] EVENT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == EVENT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/packet_handler_deadlock_qualifier.sv
// Counts consecutive block_in-high cycles and ORs the blocked-channel bits seen
// during the run; pulses qualified on the THRESHOLD-th consecutive high cycle.
module packet_handler_deadlock_qualifier
  import packet_handler_deadlock_pkg::*;
#(
  parameter int unsigned INFO_W    = 4,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block_in,
  input  logic [INFO_W-1:0] axis_block_info_in,
  input  logic              restart,
  output logic              qualified,
  output logic [INFO_W-1:0] captured_info
);

  localparam logic [15:0] LAST = 16'(THRESHOLD - 1);

  logic [15:0]       cnt_q, cnt_d;
  logic [INFO_W-1:0] acc_q, acc_d;

  always_comb begin
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    qualified     = 1'b0;
    captured_info = acc_q | axis_block_info_in;
    if (restart || !block_in) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (cnt_q == LAST) begin
      qualified = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
      acc_d = captured_info;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/packet_handler_deadlock_reporter.sv
// Qualifies monitor deadlock indications, latches a sticky record and emits one
// timestamped 64-bit report word. Optional: PACKET_HANDLER_DEADLOCK_RECOVERY_EN.
module packet_handler_deadlock_reporter
  import packet_handler_deadlock_pkg::*;
#(
  parameter int unsigned INFO_W          = 4,
  parameter int unsigned THRESHOLD       = 8,
  parameter int unsigned RECOVERY_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block_in,
  input  logic [INFO_W-1:0] axis_block_info_in,
  input  logic              clear,
  output logic [63:0]       report_tdata,
  output logic              report_tvalid,
  input  logic              report_tready,
  output logic              deadlock_flag,
  output logic [7:0]        event_count,
  output logic              recovery_rst
);

  if (INFO_W < 1 || INFO_W > INFO_MAX_W) begin : g_bad_info_w
    $error("INFO_W out of range 1..16");
  end
  if (THRESHOLD < 1 || THRESHOLD > 65535) begin : g_bad_threshold
    $error("THRESHOLD out of range 1..65535");
  end
  if (RECOVERY_CYCLES < 1 || RECOVERY_CYCLES > 255) begin : g_bad_recovery
    $error("RECOVERY_CYCLES out of range 1..255");
  end

  dl_state_e         state_q, state_d;
  logic [31:0]       tstamp_q;
  logic [31:0]       ts_q, ts_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [7:0]        event_q, event_d;
  logic              flag_q, flag_d;

  logic              restart;
  logic              qualified;
  logic [INFO_W-1:0] captured_info;
  logic              rec_start;
  logic              rec_done;

  packet_handler_deadlock_qualifier #(
    .INFO_W   (INFO_W),
    .THRESHOLD(THRESHOLD)
  ) u_qualifier (
    .clock             (clock),
    .reset             (reset),
    .block_in          (block_in),
    .axis_block_info_in(axis_block_info_in),
    .restart           (restart),
    .qualified         (qualified),
    .captured_info     (captured_info)
  );

  // Only IDLE/QUALIFY may accumulate; a block_in seen while LATCHED never counts.
  assign restart = (state_q != ST_IDLE) && (state_q != ST_QUALIFY);

  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    info_d    = info_q;
    event_d   = event_q;
    flag_d    = flag_q;
    rec_start = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_QUALIFY: begin
        if (clear) flag_d = 1'b0;
        if (qualified) begin
          state_d = ST_REPORT;
          ts_d    = tstamp_q;
          info_d  = captured_info;
          event_d = sat_inc8(event_q);
          flag_d  = 1'b1;
        end else if (block_in) begin
          state_d = ST_QUALIFY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REPORT: begin
        if (report_tready) begin
          state_d   = ST_LATCHED;
          rec_start = 1'b1;
        end
      end
      ST_LATCHED: begin
`ifdef PACKET_HANDLER_DEADLOCK_RECOVERY_EN
        if (rec_done) begin
          state_d = ST_IDLE;
          flag_d  = 1'b0;
        end
`else
        if (clear) begin
          state_d = ST_IDLE;
          flag_d  = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tstamp_q <= '0;
      ts_q     <= '0;
      info_q   <= '0;
      event_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tstamp_q <= tstamp_q + 32'd1;
      ts_q     <= ts_d;
      info_q   <= info_d;
      event_q  <= event_d;
      flag_q   <= flag_d;
    end
  end

`ifdef PACKET_HANDLER_DEADLOCK_RECOVERY_EN
  localparam logic [7:0] REC_LAST = 8'(RECOVERY_CYCLES - 1);

  logic       rec_q, rec_d;
  logic [7:0] rec_cnt_q, rec_cnt_d;

  // Pulse is loaded on the handshake edge, so it is high for exactly RECOVERY_CYCLES.
  assign rec_done = rec_q && (rec_cnt_q == '0);

  always_comb begin
    rec_d     = rec_q;
    rec_cnt_d = rec_cnt_q;
    if (rec_start) begin
      rec_d     = 1'b1;
      rec_cnt_d = REC_LAST;
    end else if (rec_done) begin
      rec_d = 1'b0;
    end else if (rec_q) begin
      rec_cnt_d = rec_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rec_q     <= 1'b0;
      rec_cnt_q <= '0;
    end else begin
      rec_q     <= rec_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  assign recovery_rst = rec_q;
`else
  assign rec_done     = 1'b0;
  assign recovery_rst = 1'b0 & rec_start & rec_done;
`endif

  always_comb begin
    report_tdata                           = '0;
    report_tdata[TS_LSB +: TS_W]           = ts_q;
    report_tdata[CNT_LSB +: CNT_W]         = event_q;
    report_tdata[INFO_LSB +: INFO_MAX_W]   = INFO_MAX_W'(info_q);
  end

  assign report_tvalid = (state_q == ST_REPORT);
  assign deadlock_flag = flag_q;
  assign event_count   = event_q;

endmodule

// File: tb/tb_packet_handler_deadlock_reporter.sv
// Directed self-checking bench for packet_handler_deadlock_reporter (THRESHOLD=8, INFO_W=4).
module tb_packet_handler_deadlock_reporter;

  logic        clock;
  logic        reset;
  logic        block_in;
  logic [3:0]  axis_block_info_in;
  logic        clear;
  logic [63:0] report_tdata;
  logic        report_tvalid;
  logic        report_tready;
  logic        deadlock_flag;
  logic [7:0]  event_count;
  logic        recovery_rst;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] tb_ts;
  logic [31:0] exp_ts;
  logic [63:0] exp_word;

  packet_handler_deadlock_reporter #(
    .INFO_W         (4),
    .THRESHOLD      (8),
    .RECOVERY_CYCLES(16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .block_in          (block_in),
    .axis_block_info_in(axis_block_info_in),
    .clear             (clear),
    .report_tdata      (report_tdata),
    .report_tvalid     (report_tvalid),
    .report_tready     (report_tready),
    .deadlock_flag     (deadlock_flag),
    .event_count       (event_count),
    .recovery_rst      (recovery_rst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference free-running timestamp.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Eight consecutive highs: info 0001 for cycles 1-4, 0100 for cycles 5-8.
  task automatic run_block8(output logic [31:0] ts_last);
    ts_last = '0;
    for (int i = 0; i < 8; i++) begin
      block_in           = 1'b1;
      axis_block_info_in = (i < 4) ? 4'b0001 : 4'b0100;
      ts_last            = tb_ts;
      step();
    end
    block_in           = 1'b0;
    axis_block_info_in = '0;
  endtask

  task automatic handshake_and_clear();
    report_tready = 1'b1;
    step();
    report_tready = 1'b0;
    clear         = 1'b1;
    step();
    clear         = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ts_tmp;
    reset = 1'b1; block_in = 1'b0; axis_block_info_in = '0;
    clear = 1'b0; report_tready = 1'b0;
    step(); step();
    check("rst_tvalid", 64'(report_tvalid), 64'd0);
    check("rst_flag",   64'(deadlock_flag), 64'd0);
    check("rst_count",  64'(event_count),   64'd0);
    check("rst_tdata",  report_tdata,       64'd0);
    check("rst_recov",  64'(recovery_rst),  64'd0);
    reset = 1'b0;
    step();

    // Seven highs then low, with tready already high: nothing qualifies.
    report_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      block_in = 1'b1; axis_block_info_in = 4'b0011;
      step();
      check("short_tvalid", 64'(report_tvalid), 64'd0);
    end
    block_in = 1'b0; axis_block_info_in = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("short_idle_tvalid", 64'(report_tvalid), 64'd0);
    end
    check("short_flag",  64'(deadlock_flag), 64'd0);
    check("short_count", 64'(event_count),   64'd0);

    // Eight highs qualify; tready drops before the report is offered.
    for (int i = 0; i < 8; i++) begin
      block_in           = 1'b1;
      axis_block_info_in = (i < 4) ? 4'b0001 : 4'b0100;
      if (i == 7) begin
        exp_ts        = tb_ts;
        report_tready = 1'b0;
      end
      step();
      if (i < 7) check("lat_early_tvalid", 64'(report_tvalid), 64'd0);
    end
    block_in = 1'b0; axis_block_info_in = '0;
    check("rpt_tvalid", 64'(report_tvalid),      64'd1);
    check("rpt_info",   64'(report_tdata[15:0]),  64'h0005);
    check("rpt_zero",   64'(report_tdata[23:16]), 64'h00);
    check("rpt_cnt",    64'(report_tdata[31:24]), 64'd1);
    check("rpt_ts",     64'(report_tdata[63:32]), 64'(exp_ts));
    check("rpt_flag",   64'(deadlock_flag),       64'd1);
    check("rpt_count",  64'(event_count),         64'd1);
    exp_word = {exp_ts, 8'd1, 8'd0, 16'h0005};

    // Backpressure for 20 cycles with a clear pulse that must be ignored.
    for (int i = 0; i < 20; i++) begin
      clear = (i == 5);
      step();
      check("hold_tvalid", 64'(report_tvalid), 64'd1);
      check("hold_tdata",  report_tdata,       exp_word);
    end
    clear = 1'b0;
    check("hold_flag", 64'(deadlock_flag), 64'd1);

    report_tready = 1'b1;
    step();
    report_tready = 1'b0;
    check("hs_tvalid", 64'(report_tvalid), 64'd0);
    check("hs_flag",   64'(deadlock_flag), 64'd1);

`ifdef PACKET_HANDLER_DEADLOCK_RECOVERY_EN
    for (int i = 0; i < 16; i++) begin
      check("rec_high", 64'(recovery_rst),  64'd1);
      check("rec_flag", 64'(deadlock_flag), 64'd1);
      clear = (i == 3);
      step();
    end
    clear = 1'b0;
    check("rec_end",      64'(recovery_rst),  64'd0);
    check("rec_flag_clr", 64'(deadlock_flag), 64'd0);
    run_block8(ts_tmp);
    check("rec_ev2_tvalid", 64'(report_tvalid), 64'd1);
    check("rec_ev2_count",  64'(event_count),   64'd2);
    check("rec_ev2_ts",     64'(report_tdata[63:32]), 64'(ts_tmp));
    report_tready = 1'b1;
    step();
    report_tready = 1'b0;
    repeat (17) step();
    check("rec2_flag",  64'(deadlock_flag), 64'd0);
    check("rec2_recov", 64'(recovery_rst),  64'd0);
`else
    // LATCHED ignores block_in.
    for (int i = 0; i < 10; i++) begin
      block_in = 1'b1; axis_block_info_in = 4'b1111;
      step();
      check("latch_tvalid", 64'(report_tvalid), 64'd0);
    end
    block_in = 1'b0; axis_block_info_in = '0;
    check("latch_flag",  64'(deadlock_flag), 64'd1);
    check("latch_count", 64'(event_count),   64'd1);
    check("latch_recov", 64'(recovery_rst),  64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_flag", 64'(deadlock_flag), 64'd0);

    run_block8(ts_tmp);
    check("ev2_tvalid", 64'(report_tvalid),      64'd1);
    check("ev2_count",  64'(event_count),        64'd2);
    check("ev2_cnt_f",  64'(report_tdata[31:24]), 64'd2);
    report_tready = 1'b1;
    step();
    report_tready = 1'b0;

    // clear together with block_in in LATCHED: that cycle must not count.
    clear = 1'b1; block_in = 1'b1; axis_block_info_in = 4'b1000;
    step();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("clrblk_tvalid", 64'(report_tvalid), 64'd0);
    end
    step();
    block_in = 1'b0; axis_block_info_in = '0;
    check("clrblk_rpt",   64'(report_tvalid),      64'd1);
    check("clrblk_count", 64'(event_count),        64'd3);
    check("clrblk_info",  64'(report_tdata[15:0]),  64'h0008);
    handshake_and_clear();

    // Saturation: events 4..256 land on 255, and a further event stays there.
    for (int e = 4; e <= 256; e++) begin
      run_block8(ts_tmp);
      check("sat_ev_tvalid", 64'(report_tvalid), 64'd1);
      handshake_and_clear();
    end
    check("sat_count", 64'(event_count),        64'd255);
    check("sat_cnt_f", 64'(report_tdata[31:24]), 64'd255);
    run_block8(ts_tmp);
    check("sat_more_count", 64'(event_count), 64'd255);
    handshake_and_clear();
`endif

    // Asynchronous reset while a report is pending.
    run_block8(ts_tmp);
    check("arst_pre_tvalid", 64'(report_tvalid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_tvalid", 64'(report_tvalid), 64'd0);
    check("arst_flag",   64'(deadlock_flag), 64'd0);
    check("arst_count",  64'(event_count),   64'd0);
    check("arst_tdata",  report_tdata,       64'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_tvalid", 64'(report_tvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
